jt6295_nibble_fetch: RTL and testbench
======================================

Name: jt6295_nibble_fetch

Overview:
- Upstream feeder for the 4-channel time-multiplexed ADPCM decoder stage.
- Holds per-channel playback state: current address, stop address, nibble phase, one-byte prefetch buffer and attenuation.
- Arbitrates a single sample-ROM read port across channels.
- Issues one {en, att, data} nibble per cen slot in fixed channel rotation 0,1,2,3.

Parameters:
- AW, 18, ROM byte-address width.

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  system clock
- cen  in  1  slot enable, one channel slot per pulse
- ctrl_we  in  1  start strobe for channel ctrl_ch
- ctrl_ch  in  2  channel index for ctrl_we
- ctrl_start  in  AW  first byte address
- ctrl_stop  in  AW  last byte address, inclusive
- ctrl_att  in  4  attenuation latched at start
- stop_req  in  4  per-channel stop strobes
- rom_cs  out  1  ROM request
- rom_addr  out  AW  ROM byte address
- rom_data  in  8  ROM byte
- rom_ok  in  1  rom_data valid for current request
- en  out  1  channel active, to decoder
- att  out  4  to decoder
- data  out  4  ADPCM nibble, to decoder
- slot  out  2  channel owning current en/att/data
- busy  out  4  per-channel playing flag
- underrun  out  4  sticky per-channel ROM-late flag

Behaviour:
- Reset: all outputs 0. Per-channel addr, stop, buf and att cleared. nib=hi, buf_valid=0, started=0. Slot counter = 0.
- Slot counter: increments mod 4 on every cen. Outputs en/att/data/slot are registered on cen for the channel indexed before the increment. Consumer samples them on the next cen.
- Start (ctrl_we, any clk, cen-independent):
  - Loads addr, stop, att for ctrl_ch.
  - Sets busy and clears nib, buf_valid, started and underrun for that channel.
  - Restart of a busy channel is allowed. If an outstanding ROM request belongs to that channel, its data is discarded (per-channel kill bit).
- Stop: stop_req[i] clears busy[i] next clk. If ctrl_we targets the same channel in the same cycle, start wins.
- Slot processing for channel c:
  - ~busy: en=0, data=0.
  - busy & ~buf_valid & ~started: en=0, data=0. The decoder holds reset state while the first byte is fetched.
  - busy & ~buf_valid & started: en=1, data=0, underrun[c] set, addr and nib unchanged.
  - busy & buf_valid: en=1, started=1. Emits buf[7:4] when nib=hi, buf[3:0] when nib=lo, then toggles nib.
  - After a lo nibble: buf_valid=0. If addr==stop, busy clears; otherwise addr advances by 1.
  - att is output whenever en=1, else 0.
- Address arithmetic:
  - addr wraps mod 2^AW.
  - Termination is by equality only, so start>stop plays through the wrap.
  - start==stop plays exactly 2 nibbles.
- ROM arbiter:
  - At most one request outstanding.
  - When idle, selects the next channel with busy & ~buf_valid & ~pending, round-robin starting after the last granted channel.
  - rom_cs and rom_addr are held stable until rom_ok is sampled high. rom_cs drops the next clk; a new request may issue the cycle after.
  - On rom_ok: buf<=rom_data and buf_valid=1, unless the channel was killed or stopped, in which case the data is dropped.
- Bandwidth: each channel needs 1 byte per 8 cen. Meeting the hi-nibble deadline requires ROM latency ≤ 4 cen minus arbitration wait; lateness is reported through underrun, never through a stall.
- Reset mid-request: rom_cs drops immediately and all state is cleared.

Decomposition:
- Shared package holds:
  - the nibble-phase encoding (HI=0, LO=1);
  - the slot-count constant NCH=4;
  - the default AW.
- Sub-module jt6295_rom_arb is natural: round-robin request selection plus the request/ok handshake and kill tracking.
- Per-channel registers are kept as arrays in the top module.

Test Plan:
- Start ch1, start=0x00100, stop=0x00101, att=3; ROM returns 0xA7, 0x3C with 1-clk latency.
  - ch1 slots give en=0 once, then data A,7,3,C with en=1, att=3.
  - busy[1] falls after C; next ch1 slot en=0.
- Start ch2 with start=0x3FFFF, stop=0x00000.
  - rom_addr sequence 0x3FFFF then 0x00000.
  - 4 nibbles emitted, then idle.
- ROM latency 20 cen on ch0 after the first byte.
  - Next hi slot gives en=1, data=0, underrun[0]=1.
  - Nibble resumes when the byte arrives; no address skipped.
- All four channels started the same cycle.
  - rom_addr granted in order 0,1,2,3.
  - rom_cs never drops before rom_ok.
  - Per-channel nibble streams match their ROM images.
- stop_req[3] and ctrl_we ch3 in the same clk: ch3 restarts from the new start address.
  - The pending old ch3 byte returned later is discarded and not emitted.
- rst asserted while rom_cs=1 mid-playback: all outputs 0 immediately; busy=0 and slot=0 after release.

Source files
------------

// File: rtl/jt6295_nibble_fetch_pkg.sv
// Shared constants and encodings for the jt6295 nibble fetch stage.
package jt6295_nibble_fetch_pkg;
  localparam int NCH        = 4;
  localparam int AW_DEFAULT = 18;

  typedef enum logic {
    NIB_HI = 1'b0,
    NIB_LO = 1'b1
  } nib_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_REQ  = 1'b1
  } arb_state_e;
endpackage

// File: rtl/jt6295_rom_arb.sv
// Round-robin sample-ROM arbiter: one outstanding request, with a kill bit for
// requests whose channel was restarted while the byte was in flight.
module jt6295_rom_arb
  import jt6295_nibble_fetch_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   need,
  input  logic [AW-1:0]    ch_addr [NCH],
  input  logic             start_we,
  input  logic [1:0]       start_ch,
  input  logic             rom_ok,
  output logic [AW-1:0]    rom_addr,
  output logic             fill_we,
  output logic [1:0]       fill_ch,
  output arb_state_e       state
);
  // Handshake: rom_cs (state == ARB_REQ) and rom_addr stay frozen from grant
  // until the clock edge that samples rom_ok high; the following cycle is
  // always idle, so a new grant appears at the earliest one cycle after that.
  arb_state_e state_nx;
  logic [1:0] last;
  logic [1:0] grant;
  logic [1:0] idx;
  logic [1:0] sel;
  logic       found;
  logic       kill;

  always_comb begin
    found    = 1'b0;
    sel      = last;
    idx      = '0;
    state_nx = state;
    fill_we  = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      idx = last + 2'(i);
      if (!found && need[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    case (state)
      ARB_IDLE: if (found) state_nx = ARB_REQ;
      ARB_REQ: begin
        if (rom_ok) begin
          state_nx = ARB_IDLE;
          fill_we  = !kill && !(start_we && start_ch == grant);
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      last     <= 2'd3;
      grant    <= 2'd0;
      kill     <= 1'b0;
      rom_addr <= '0;
    end else begin
      state <= state_nx;
      if (state == ARB_IDLE && found) begin
        grant    <= sel;
        last     <= sel;
        rom_addr <= ch_addr[sel];
        kill     <= start_we && start_ch == sel;
      end else if (state == ARB_REQ && start_we && start_ch == grant) begin
        kill <= 1'b1;
      end
    end
  end

  assign fill_ch = grant;
endmodule

// File: rtl/jt6295_nibble_fetch.sv
// Per-channel playback state and nibble issue for the 4-slot ADPCM decoder,
// fed from one shared sample-ROM port.
module jt6295_nibble_fetch
  import jt6295_nibble_fetch_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic          ctrl_we,
  input  logic [1:0]    ctrl_ch,
  input  logic [AW-1:0] ctrl_start,
  input  logic [AW-1:0] ctrl_stop,
  input  logic [3:0]    ctrl_att,
  input  logic [3:0]    stop_req,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic          en,
  output logic [3:0]    att,
  output logic [3:0]    data,
  output logic [1:0]    slot,
  output logic [3:0]    busy,
  output logic [3:0]    underrun
);
  logic [AW-1:0]  addr     [NCH];
  logic [AW-1:0]  stop_a   [NCH];
  logic [7:0]     byte_buf [NCH];
  logic [3:0]     att_q    [NCH];
  nib_e           nib      [NCH];
  logic [NCH-1:0] buf_valid;
  logic [NCH-1:0] started;
  logic [NCH-1:0] need;
  logic [1:0]     slot_cnt;
  logic           fill_we;
  logic [1:0]     fill_ch;
  arb_state_e     arb_state;

  assign need   = busy & ~buf_valid;
  assign rom_cs = (arb_state == ARB_REQ);

  jt6295_rom_arb #(.AW(AW)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .need     (need),
    .ch_addr  (addr),
    .start_we (ctrl_we),
    .start_ch (ctrl_ch),
    .rom_ok   (rom_ok),
    .rom_addr (rom_addr),
    .fill_we  (fill_we),
    .fill_ch  (fill_ch),
    .state    (arb_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        addr[i]     <= '0;
        stop_a[i]   <= '0;
        byte_buf[i] <= '0;
        att_q[i]    <= '0;
        nib[i]      <= NIB_HI;
      end
      buf_valid <= '0;
      started   <= '0;
      busy      <= '0;
      underrun  <= '0;
      slot_cnt  <= '0;
      slot      <= '0;
      en        <= 1'b0;
      att       <= '0;
      data      <= '0;
    end else begin
      if (cen) begin
        slot     <= slot_cnt;
        slot_cnt <= slot_cnt + 2'd1;
        en       <= 1'b0;
        att      <= '0;
        data     <= '0;
        if (busy[slot_cnt]) begin
          if (buf_valid[slot_cnt]) begin
            en                <= 1'b1;
            att               <= att_q[slot_cnt];
            started[slot_cnt] <= 1'b1;
            data <= (nib[slot_cnt] == NIB_HI) ? byte_buf[slot_cnt][7:4]
                                              : byte_buf[slot_cnt][3:0];
            nib[slot_cnt] <= (nib[slot_cnt] == NIB_HI) ? NIB_LO : NIB_HI;
            if (nib[slot_cnt] == NIB_LO) begin
              buf_valid[slot_cnt] <= 1'b0;
              if (addr[slot_cnt] == stop_a[slot_cnt]) busy[slot_cnt] <= 1'b0;
              else addr[slot_cnt] <= addr[slot_cnt] + AW'(1);
            end
          end else if (started[slot_cnt]) begin
            // ROM was late: keep the decoder clocked with a zero nibble
            en                 <= 1'b1;
            att                <= att_q[slot_cnt];
            underrun[slot_cnt] <= 1'b1;
          end
        end
      end
      if (fill_we && busy[fill_ch] && !stop_req[fill_ch]) begin
        byte_buf[fill_ch]  <= rom_data;
        buf_valid[fill_ch] <= 1'b1;
      end
      for (int i = 0; i < NCH; i++) begin
        if (stop_req[i]) busy[i] <= 1'b0;
      end
      // A start overrides stop, slot and fill updates on the same channel
      if (ctrl_we) begin
        addr[ctrl_ch]      <= ctrl_start;
        stop_a[ctrl_ch]    <= ctrl_stop;
        att_q[ctrl_ch]     <= ctrl_att;
        nib[ctrl_ch]       <= NIB_HI;
        busy[ctrl_ch]      <= 1'b1;
        buf_valid[ctrl_ch] <= 1'b0;
        started[ctrl_ch]   <= 1'b0;
        underrun[ctrl_ch]  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_jt6295_nibble_fetch.sv
// Directed bench for jt6295_nibble_fetch with a latency-programmable ROM model.
module tb_jt6295_nibble_fetch;
  localparam int AW = 18;

  logic          rst, clk, cen, ctrl_we;
  logic [1:0]    ctrl_ch;
  logic [AW-1:0] ctrl_start, ctrl_stop;
  logic [3:0]    ctrl_att, stop_req;
  logic          rom_cs, rom_ok;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          en;
  logic [3:0]    att, data, busy, underrun;
  logic [1:0]    slot;

  int n_assert = 0;
  int n_fail   = 0;
  int phase    = 0;
  int mon_ch   = 0;
  int mon_cur  = 0;
  logic [8:0]    mq0[$], mq1[$], mq2[$], mq3[$];
  logic [8:0]    exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [7:0]    rom_mem [logic [AW-1:0]];

  jt6295_nibble_fetch #(.AW(AW)) dut (
    .rst(rst), .clk(clk), .cen(cen), .ctrl_we(ctrl_we), .ctrl_ch(ctrl_ch),
    .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .ctrl_att(ctrl_att),
    .stop_req(stop_req), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .en(en), .att(att), .data(data),
    .slot(slot), .busy(busy), .underrun(underrun)
  );

  // clock/reset block: cen is high on every fourth rising edge
  initial begin
    clk = 0;
    cen = 0;
    forever begin
      #5 clk = 1;
      #5 clk = 0;
      phase++;
      cen = (phase % 4 == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] rec(input logic e, input logic [3:0] a, input logic [3:0] d);
    return {e, a, d};
  endfunction

  function automatic int lat_of(input logic [AW-1:0] a);
    case (a)
      18'h00201: return 80;
      18'h00300: return 40;
      18'h00501: return 40;
      default:   return 1;
    endcase
  endfunction

  function automatic logic [7:0] rom_rd(input logic [AW-1:0] a);
    return rom_mem.exists(a) ? rom_mem[a] : 8'h00;
  endfunction

  // slot monitor: the bench keeps its own rotation model to route records
  always @(posedge clk) begin
    if (rst) mon_ch = 0;
    else if (cen) begin
      mon_cur = mon_ch;
      mon_ch  = (mon_ch + 1) % 4;
      #1;
      check("slot", {30'd0, slot}, mon_cur);
      case (mon_cur)
        0: mq0.push_back({en, att, data});
        1: mq1.push_back({en, att, data});
        2: mq2.push_back({en, att, data});
        default: mq3.push_back({en, att, data});
      endcase
    end
  end

  // ROM model: answers after lat_of(addr) clocks and checks request stability
  initial begin
    int cnt;
    logic [AW-1:0] held;
    cnt = 0; held = '0; rom_ok = 0; rom_data = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0; rom_ok = 0;
      end else if (rom_ok) begin
        rom_ok = 0; cnt = 0;
      end else if (cnt > 0) begin
        check("rom_cs_held", {13'd0, rom_cs, rom_addr}, {13'd0, 1'b1, held});
        cnt++;
        if (cnt >= lat_of(held)) begin rom_ok = 1; rom_data = rom_rd(held); end
      end else if (rom_cs) begin
        held = rom_addr;
        addr_q.push_back(rom_addr);
        cnt = 1;
        if (lat_of(held) <= 1) begin rom_ok = 1; rom_data = rom_rd(held); end
      end
    end
  end

  function automatic int qsz(input int ch);
    case (ch)
      0: return mq0.size();
      1: return mq1.size();
      2: return mq2.size();
      default: return mq3.size();
    endcase
  endfunction

  task automatic flush();
    mq0.delete(); mq1.delete(); mq2.delete(); mq3.delete();
  endtask

  task automatic pop(input int ch, output logic [8:0] r);
    int t;
    t = 0;
    r = '1;
    while (qsz(ch) == 0 && t < 200) begin @(negedge clk); t++; end
    if (qsz(ch) == 0) begin
      n_assert++; n_fail++;
      $display("FAIL pop_timeout ch%0d: no slot record after %0d cycles, expected one", ch, t);
    end else begin
      case (ch)
        0: r = mq0.pop_front();
        1: r = mq1.pop_front();
        2: r = mq2.pop_front();
        default: r = mq3.pop_front();
      endcase
    end
  endtask

  task automatic expect_rec(input int ch, input string tag, input logic [8:0] e);
    logic [8:0] r;
    pop(ch, r);
    check(tag, {23'd0, r}, {23'd0, e});
  endtask

  task automatic skip_idle(input int ch, output logic [8:0] r);
    int g;
    g = 0;
    pop(ch, r);
    while (r[8] == 1'b0 && g < 40) begin pop(ch, r); g++; end
  endtask

  // compare the remaining nibbles of a channel against exp_q, then one idle slot
  task automatic drain_exp(input int ch, input string tag);
    logic [8:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      expect_rec(ch, tag, e);
    end
    expect_rec(ch, {tag, "_idle"}, 9'h000);
  endtask

  task automatic start(input int ch, input logic [AW-1:0] s, input logic [AW-1:0] e,
                       input logic [3:0] a, input bit align, input logic [3:0] stp);
    int t;
    t = 0;
    do begin @(negedge clk); #1; t++; end
    while (align && !(phase % 4 == 3 && mon_ch == ch) && t < 64);
    ctrl_we = 1; ctrl_ch = ch[1:0]; ctrl_start = s; ctrl_stop = e; ctrl_att = a;
    stop_req = stp;
    @(posedge clk); #1;
    ctrl_we = 0; stop_req = 0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while ((busy != 4'd0 || rom_cs) && t < 3000) begin @(negedge clk); t++; end
    if (busy != 4'd0 || rom_cs) begin
      n_assert++; n_fail++;
      $display("FAIL %s: busy=%0h rom_cs=%0b after %0d cycles, expected idle", tag, busy, rom_cs, t);
    end
  endtask

  task automatic wait_req(input logic [AW-1:0] a, input string tag);
    int t;
    t = 0;
    while (!(rom_cs && rom_addr == a) && t < 200) begin @(negedge clk); t++; end
    if (!(rom_cs && rom_addr == a)) begin
      n_assert++; n_fail++;
      $display("FAIL %s: no request for %0h seen, rom_addr=%0h", tag, a, rom_addr);
    end
  endtask

  initial begin
    logic [8:0] r;
    int under;
    rst = 1; ctrl_we = 0; ctrl_ch = 0; ctrl_start = 0; ctrl_stop = 0;
    ctrl_att = 0; stop_req = 0;
    rom_mem[18'h00100] = 8'hA7; rom_mem[18'h00101] = 8'h3C;
    rom_mem[18'h3FFFF] = 8'h51; rom_mem[18'h00000] = 8'h9E;
    rom_mem[18'h00200] = 8'h12; rom_mem[18'h00201] = 8'h34; rom_mem[18'h00202] = 8'h56;
    rom_mem[18'h01000] = 8'h01; rom_mem[18'h01001] = 8'h23;
    rom_mem[18'h02000] = 8'h45; rom_mem[18'h02001] = 8'h67;
    rom_mem[18'h03000] = 8'h89; rom_mem[18'h03001] = 8'hAB;
    rom_mem[18'h04000] = 8'hCD; rom_mem[18'h04001] = 8'hEF;
    rom_mem[18'h00300] = 8'hFF; rom_mem[18'h00400] = 8'hD2;
    rom_mem[18'h00500] = 8'h4B; rom_mem[18'h00501] = 8'h99;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {rom_cs, en, att, data, slot, busy, underrun}, 20'd0);
    check("rst_addr", {14'd0, rom_addr}, 32'd0);
    @(negedge clk); rst = 0;

    // 1: two-byte playback on ch1
    start(1, 18'h00100, 18'h00101, 4'd3, 1, 4'd0);
    flush();
    expect_rec(1, "t1_first_idle", 9'h000);
    exp_q.push_back(rec(1, 3, 4'hA)); exp_q.push_back(rec(1, 3, 4'h7));
    exp_q.push_back(rec(1, 3, 4'h3)); exp_q.push_back(rec(1, 3, 4'hC));
    while (exp_q.size() > 1) expect_rec(1, "t1_nib", exp_q.pop_front());
    expect_rec(1, "t1_last", exp_q.pop_front());
    check("t1_busy_off", {31'd0, busy[1]}, 32'd0);
    expect_rec(1, "t1_idle", 9'h000);
    wait_idle("t1_wait");

    // 2: address wrap
    addr_q.delete();
    start(2, 18'h3FFFF, 18'h00000, 4'd5, 0, 4'd0);
    flush();
    skip_idle(2, r);
    check("t2_first", {23'd0, r}, {23'd0, rec(1, 5, 4'h5)});
    exp_q.push_back(rec(1, 5, 4'h1)); exp_q.push_back(rec(1, 5, 4'h9));
    exp_q.push_back(rec(1, 5, 4'hE));
    drain_exp(2, "t2_nib");
    wait_idle("t2_wait");
    check("t2_nreq", addr_q.size(), 2);
    check("t2_addr0", {14'd0, addr_q[0]}, 32'h3FFFF);
    check("t2_addr1", {14'd0, addr_q[1]}, 32'h00000);

    // 3: late ROM on the second byte of ch0
    addr_q.delete();
    start(0, 18'h00200, 18'h00202, 4'd9, 1, 4'd0);
    flush();
    expect_rec(0, "t3_first_idle", 9'h000);
    expect_rec(0, "t3_n0", rec(1, 9, 4'h1));
    expect_rec(0, "t3_n1", rec(1, 9, 4'h2));
    under = 0;
    pop(0, r);
    while (r === rec(1, 9, 4'h0) && under < 10) begin under++; pop(0, r); end
    check("t3_under_slots", under, 5);
    check("t3_resume", {23'd0, r}, {23'd0, rec(1, 9, 4'h3)});
    check("t3_underrun", {28'd0, underrun}, 32'h1);
    exp_q.push_back(rec(1, 9, 4'h4)); exp_q.push_back(rec(1, 9, 4'h5));
    exp_q.push_back(rec(1, 9, 4'h6));
    drain_exp(0, "t3_nib");
    wait_idle("t3_wait");
    check("t3_nreq", addr_q.size(), 3);
    check("t3_addr2", {14'd0, addr_q[1]}, 32'h00201);
    check("t3_addr3", {14'd0, addr_q[2]}, 32'h00202);

    // 4: all channels started on consecutive clocks
    addr_q.delete();
    flush();
    start(0, 18'h01000, 18'h01001, 4'd1, 0, 4'd0);
    start(1, 18'h02000, 18'h02001, 4'd2, 0, 4'd0);
    start(2, 18'h03000, 18'h03001, 4'd3, 0, 4'd0);
    start(3, 18'h04000, 18'h04001, 4'd4, 0, 4'd0);
    for (int c = 0; c < 4; c++) begin
      skip_idle(c, r);
      check("t4_first", {23'd0, r}, {23'd0, rec(1, 4'(c + 1), 4'(4 * c))});
      for (int k = 1; k < 4; k++) exp_q.push_back(rec(1, 4'(c + 1), 4'(4 * c + k)));
      drain_exp(c, "t4_nib");
    end
    wait_idle("t4_wait");
    check("t4_underrun", {28'd0, underrun}, 32'h0);
    check("t4_grant0", {14'd0, addr_q[0]}, 32'h01000);
    check("t4_grant1", {14'd0, addr_q[1]}, 32'h02000);
    check("t4_grant2", {14'd0, addr_q[2]}, 32'h03000);
    check("t4_grant3", {14'd0, addr_q[3]}, 32'h04000);

    // 5: stop and restart of ch3 in the same clock while its byte is in flight
    addr_q.delete();
    start(3, 18'h00300, 18'h00301, 4'd7, 0, 4'd0);
    wait_req(18'h00300, "t5_req");
    start(3, 18'h00400, 18'h00400, 4'd6, 0, 4'b1000);
    flush();
    check("t5_busy", {28'd0, busy}, 32'h8);
    skip_idle(3, r);
    check("t5_first", {23'd0, r}, {23'd0, rec(1, 6, 4'hD)});
    exp_q.push_back(rec(1, 6, 4'h2));
    drain_exp(3, "t5_nib");
    wait_idle("t5_wait");
    check("t5_nreq", addr_q.size(), 2);
    check("t5_addr1", {14'd0, addr_q[1]}, 32'h00400);
    check("t5_underrun", {28'd0, underrun}, 32'h0);

    // 6: reset in the middle of a ROM request
    start(1, 18'h00500, 18'h005FF, 4'd8, 0, 4'd0);
    wait_req(18'h00501, "t6_req");
    @(negedge clk); #2;
    rst = 1;
    #1;
    check("t6_rst_outs", {rom_cs, en, att, data, slot, busy, underrun}, 20'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    #1;
    check("t6_rel_busy_slot", {busy, slot}, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("t6_quiet", {rom_cs, en, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
